instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: byte address of the requested word, always equal to pc.
REQ-006 The block SHALL have port imem_ready, input, 1 bit: read data valid this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-008 The block SHALL have port instr_valid, output, 1 bit: the instruction register (IR) holds an instruction not yet consumed.
REQ-009 The block SHALL have port instr_ready, input, 1 bit: downstream consumes the IR this cycle.
REQ-010 The block SHALL have port pc_src, input, 2 bits: next-PC select (00 seq, 01 branch, 10 jump, 11 register).
REQ-011 The block SHALL have port branch_off, input, 32 bits: sign-extended word offset from the immediate extender.
REQ-012 The block SHALL have port jr_addr, input, 32 bits: register-indirect target.
REQ-013 The block SHALL have port pc, output, 32 bits: address of the instruction in the IR.
REQ-014 The block SHALL have port instr, output, 32 bits: IR contents.
REQ-015 The block SHALL have ports opcode[5:0], rs[4:0], rt[4:0], rd[4:0], shamt[4:0], funct[5:0], imm16[15:0] and jtarget[25:0], all outputs, driven combinationally from IR bit fields 31:26, 25:21, 20:16, 15:11, 10:6, 5:0, 15:0 and 25:0.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH and HOLD.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-018 In FETCH, imem_req SHALL be 1; in IDLE and HOLD it SHALL be 0.
REQ-019 In FETCH with imem_ready=1, the IR SHALL load imem_rdata on that edge and the FSM SHALL go to HOLD; with imem_ready=0 the FSM SHALL stay in FETCH with the address held.
REQ-020 imem_ready SHALL be ignored outside FETCH.
REQ-021 instr_valid SHALL be 1 exactly while in HOLD.
REQ-022 In HOLD, instr_ready=0 SHALL hold pc and the IR unchanged.
REQ-023 In HOLD with instr_ready=1, pc SHALL update per pc_src, branch_off and jr_addr sampled that cycle, and the FSM SHALL go to FETCH.
REQ-024 Next-PC rules, all modulo 2^32 with carries beyond bit 31 discarded:
- seq: pc+4
- branch: pc+4+(branch_off<<2)
- jump: {pc_plus4[31:28], jtarget, 2'b00}
- register: {jr_addr[31:2], 2'b00}
REQ-025 Minimum throughput SHALL be one instruction per 2 cycles (FETCH with ready, then HOLD with ready).
REQ-026 pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 on seq.

Reset
REQ-027 While rst_n=0, the block SHALL hold: state IDLE, pc=RESET_PC, IR=32'h0 (nop), instr_valid=0, imem_req=0.
REQ-028 Reset asserted mid-FETCH or mid-HOLD SHALL abort immediately, discarding any pending read data.

Structure
REQ-029 Package cpu_pkg SHALL hold the pc_src encodings (PC_SEQ, PC_BR, PC_J, PC_JR), the FSM state type and the IR field position constants.
REQ-030 Next-PC computation SHALL be a separate combinational sub-module pc_next (inputs pc, pc_src, branch_off, jtarget, jr_addr; output npc).

Verification
REQ-031 Reset release, imem_ready always 1, instr_ready always 1, pc_src=00 -> imem_addr sequence 0,4,8,... with one new instr_valid pulse every 2 cycles.
REQ-032 imem_ready held 0 for 3 cycles in FETCH -> imem_addr stable, instr_valid 0, IR loaded on the first ready cycle.
REQ-033 HOLD with instr_ready=0 for 4 cycles -> pc, instr and instr_valid unchanged; the next fetch occurs only after instr_ready=1.
REQ-034 pc=32'h0000_0100, branch with branch_off=32'hFFFF_FFFE -> next pc=32'h0000_00FC; jump with jtarget=26'h000_0010 from pc=32'h1000_0000 -> next pc=32'h1000_0040.
REQ-035 Register jump with jr_addr=32'h0000_2003 -> next pc=32'h0000_2000; seq from pc=32'hFFFF_FFFC -> next pc=32'h0.
REQ-036 rst_n dropped in HOLD with instr=32'h2408_FFFF -> instr=0, pc=RESET_PC, instr_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the instruction-fetch slice.
//   - pc_src encodings selecting the next-PC source
//   - FSM state type and state constants for instr_fetch
//   - bit positions of the instruction-register fields
package cpu_pkg;

    // Next-PC source select
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    // Fetch FSM state type and encodings
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;

    // Instruction-register field positions (MSB/LSB)
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int JT_MSB    = 25;
    localparam int JT_LSB    = 0;

endpackage : cpu_pkg

// File: rtl/pc_next.sv
// pc_next: combinational next-PC calculation.
// Ports:
//   pc         in  [31:0] current instruction address
//   pc_src     in  [1:0]  source select (seq / branch / jump / register)
//   branch_off in  [31:0] sign-extended word offset
//   jtarget    in  [25:0] jump target word index
//   jr_addr    in  [31:0] register-indirect target
//   npc        out [31:0] next PC (all arithmetic modulo 2^32)
module pc_next
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_off,
    input  logic [25:0] jtarget,
    input  logic [31:0] jr_addr,
    output logic [31:0] npc
);

    logic [31:0] pc_plus4_s;
    logic [31:0] br_target_s;

    assign pc_plus4_s  = pc + 32'd4;
    // Word offset becomes a byte offset; bits shifted out of 31 are discarded.
    assign br_target_s = pc_plus4_s + (branch_off << 2);

    // Select the next PC by source
    always_comb begin
        npc = pc_plus4_s;
        case (pc_src)
            PC_SEQ:  npc = pc_plus4_s;
            PC_BR:   npc = br_target_s;
            PC_J:    npc = {pc_plus4_s[31:28], jtarget, 2'b00};
            // Register targets are forced word-aligned.
            PC_JR:   npc = jr_addr & 32'hFFFF_FFFC;
            default: npc = pc_plus4_s;
        endcase
    end

endmodule : pc_next

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a single instruction register.
// FSM: IDLE (one cycle after reset) -> FETCH (request until imem_ready)
//      -> HOLD (IR valid until instr_ready) -> FETCH ...
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req / imem_addr       read request and word address (== pc)
//   imem_ready / imem_rdata    read data valid and data
//   instr_valid / instr_ready  IR handshake with the consumer
//   pc_src, branch_off, jr_addr next-PC controls, sampled when IR consumed
//   pc, instr                  address and contents of the IR
//   opcode .. jtarget          decoded IR bit fields
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_off,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jtarget
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic [31:0]  npc_s;

    pc_next u_pc_next (
        .pc         (pc_q),
        .pc_src     (pc_src),
        .branch_off (branch_off),
        .jtarget    (ir_q[JT_MSB:JT_LSB]),
        .jr_addr    (jr_addr),
        .npc        (npc_s)
    );

    // Next-state, PC and IR update logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    pc_d    = npc_s;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake outputs are registered from the upcoming state so they
        // line up exactly with the state they describe.
        req_d   = (state_d == ST_FETCH);
        valid_d = (state_d == ST_HOLD);
    end

    // State, PC, IR and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign instr       = ir_q;

    assign opcode  = ir_q[OPC_MSB:OPC_LSB];
    assign rs      = ir_q[RS_MSB:RS_LSB];
    assign rt      = ir_q[RT_MSB:RT_LSB];
    assign rd      = ir_q[RD_MSB:RD_LSB];
    assign shamt   = ir_q[SHAMT_MSB:SHAMT_LSB];
    assign funct   = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign imm16   = ir_q[IMM_MSB:IMM_LSB];
    assign jtarget = ir_q[JT_MSB:JT_LSB];

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
// Fetched words are pushed to a scoreboard when returned to the DUT and
// popped/compared when instr_valid is observed.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  pc_src;
    logic [31:0] branch_off;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jtarget;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_src      (pc_src),
        .branch_off  (branch_off),
        .jr_addr     (jr_addr),
        .pc          (pc),
        .instr       (instr),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm16       (imm16),
        .jtarget     (jtarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the IR against the oldest scoreboard entry
    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        n_run++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_pc"}, pc, e.pc);
            chk({tag, "_instr"}, instr, e.ins);
        end
    endtask

    // From FETCH at exp_pc: return word, land in HOLD and check the IR
    task automatic fetch_hold(input string tag, input logic [31:0] exp_pc, input logic [31:0] word);
        exp_t e;
        chk({tag, "_addr"}, imem_addr, exp_pc);
        imem_ready = 1'b1;
        imem_rdata = word;
        e.pc  = exp_pc;
        e.ins = word;
        sb.push_back(e);
        step();
        pop_check(tag);
    endtask

    initial begin
        logic [31:0] a;
        exp_t        e;
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        pc_src      = 2'b00;
        branch_off  = 32'h0;
        jr_addr     = 32'h0;

        // Reset state
        #12;
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc",    pc,    RST_PC);
        chk("rst_instr", instr, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        step();  // IDLE -> FETCH
        chk("idle_exit_req",   {31'd0, imem_req},    32'd1);
        chk("idle_exit_valid", {31'd0, instr_valid}, 32'd0);

        // Back-to-back sequential stream: one instruction every 2 cycles
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        pc_src      = 2'b00;
        a = RST_PC;
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", imem_addr, a);
            chk("seq_req",  {31'd0, imem_req}, 32'd1);
            imem_rdata = mem_word(a);
            e.pc  = a;
            e.ins = mem_word(a);
            sb.push_back(e);
            step();
            pop_check("seq");
            chk("seq_hold_req", {31'd0, imem_req}, 32'd0);
            step();
            chk("seq_fetch_valid", {31'd0, instr_valid}, 32'd0);
            a = a + 32'd4;
        end

        // Memory stall for 3 cycles
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr",  imem_addr, a);
            chk("stall_valid", {31'd0, instr_valid}, 32'd0);
            chk("stall_instr", instr, mem_word(a - 32'd4));
        end
        instr_ready = 1'b0;
        fetch_hold("stall_done", a, mem_word(a));

        // Consumer back-pressure for 4 cycles; memory readiness is ignored
        imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_pc",    pc,    a);
            chk("bp_instr", instr, mem_word(a));
            chk("bp_req",   {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        step();
        chk("bp_release_addr", imem_addr, a + 32'd4);
        chk("bp_release_req",  {31'd0, imem_req}, 32'd1);
        a = a + 32'd4;

        // Register jump to 0x100
        fetch_hold("to100", a, 32'h0000_0000);
        pc_src  = 2'b11;
        jr_addr = 32'h0000_0100;
        step();
        chk("jr_100", imem_addr, 32'h0000_0100);

        // Backward branch: 0x100 + 4 - 8
        fetch_hold("br", 32'h0000_0100, 32'h1111_1111);
        pc_src     = 2'b01;
        branch_off = 32'hFFFF_FFFE;
        step();
        chk("br_neg", imem_addr, 32'h0000_00FC);

        // Register jump to 0x1000_0000
        fetch_hold("to1000", 32'h0000_00FC, 32'h2222_2222);
        pc_src  = 2'b11;
        jr_addr = 32'h1000_0000;
        step();
        chk("jr_1000", imem_addr, 32'h1000_0000);

        // Jump, jtarget = 0x10 taken from the IR
        fetch_hold("j", 32'h1000_0000, 32'h0800_0010);
        chk("j_field", {6'd0, jtarget}, 32'h0000_0010);
        pc_src = 2'b10;
        step();
        chk("j_target", imem_addr, 32'h1000_0040);

        // Register jump with misaligned target
        fetch_hold("jr", 32'h1000_0040, 32'h3333_3333);
        pc_src  = 2'b11;
        jr_addr = 32'h0000_2003;
        step();
        chk("jr_align", imem_addr, 32'h0000_2000);

        // Sequential wrap from the top of the address space
        fetch_hold("towrap", 32'h0000_2000, 32'h4444_4444);
        jr_addr = 32'hFFFF_FFFC;
        step();
        chk("jr_top", imem_addr, 32'hFFFF_FFFC);
        fetch_hold("wrap", 32'hFFFF_FFFC, 32'h5555_5555);
        pc_src = 2'b00;
        step();
        chk("seq_wrap", imem_addr, 32'h0000_0000);

        // Field decode, then asynchronous reset while in HOLD
        instr_ready = 1'b0;
        fetch_hold("fld", 32'h0000_0000, 32'h2408_FFFF);
        chk("fld_opcode",  {26'd0, opcode}, 32'h0000_0009);
        chk("fld_rs",      {27'd0, rs},     32'h0000_0000);
        chk("fld_rt",      {27'd0, rt},     32'h0000_0008);
        chk("fld_rd",      {27'd0, rd},     32'h0000_001F);
        chk("fld_shamt",   {27'd0, shamt},  32'h0000_001F);
        chk("fld_funct",   {26'd0, funct},  32'h0000_003F);
        chk("fld_imm16",   {16'd0, imm16},  32'h0000_FFFF);
        chk("fld_jtarget", {6'd0, jtarget}, 32'h0008_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hold_instr", instr, 32'h0);
        chk("arst_hold_pc",    pc,    RST_PC);
        chk("arst_hold_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_hold_req",   {31'd0, imem_req},    32'd0);

        // Reset during FETCH with data ready: the read is discarded
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fetch_req",   {31'd0, imem_req}, 32'd0);
        chk("arst_fetch_instr", instr, 32'h0);
        step();
        chk("arst_held_instr", instr, 32'h0);
        chk("arst_held_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_addr",  imem_addr, RST_PC);
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_rst_instr", instr, 32'h0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch
